// File: rtl/st_packet_channel_arbiter_pkg.sv
// Shared types and the round-robin search used by the packet channel arbiter.
package st_arb_pkg;

  localparam int MAX_IN = 8;
  localparam int IDX_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_t;

  // First set bit of valid, scanning upward from last+1 and wrapping at num.
  function automatic rr_t rr_next(input logic [MAX_IN-1:0] valid,
                                  input logic [IDX_W-1:0]  last,
                                  input int                num);
    rr_t              r;
    int               i;
    logic [IDX_W-1:0] ii;
    r = '0;
    for (int k = 1; k <= MAX_IN; k++) begin
      i  = (int'(last) + k) % num;
      ii = IDX_W'(i);
      if (k <= num && !r.found && valid[ii]) begin
        r.found = 1'b1;
        r.idx   = ii;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/st_packet_channel_arbiter_out_reg.sv
// One-entry registered output stage; accepts a new beat whenever empty or draining.
module st_out_reg #(
  parameter int DATA_W    = 8,
  parameter int CHANNEL_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_W-1:0]    data,
  input  logic [CHANNEL_W-1:0] channel,
  input  logic                 sop,
  input  logic                 eop,
  input  logic                 out_ready,
  output logic                 accept,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic [CHANNEL_W-1:0] out_channel,
  output logic                 out_startofpacket,
  output logic                 out_endofpacket
);

  assign accept = !out_valid || out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_channel       <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
    end else if (accept) begin
      out_valid <= load;
      if (load) begin
        out_data          <= data;
        out_channel       <= channel;
        out_startofpacket <= sop;
        out_endofpacket   <= eop;
      end
    end
  end

endmodule

// File: rtl/st_packet_channel_arbiter.sv
// Packet-atomic round-robin arbiter merging NUM_IN Avalon-ST sources onto one
// registered stream, tagging each beat with the winning source index.
module st_packet_channel_arbiter
  import st_arb_pkg::*;
#(
  parameter int NUM_IN    = 2,
  parameter int DATA_W    = 8,
  parameter int CHANNEL_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_startofpacket,
  input  logic [NUM_IN-1:0]        in_endofpacket,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CHANNEL_W-1:0]     out_channel,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic                     proto_err
);

  if (NUM_IN < 1 || NUM_IN > MAX_IN) begin : g_bad_num_in
    $error("st_packet_channel_arbiter: NUM_IN must be in 1..8");
  end
  if ($clog2(NUM_IN) > CHANNEL_W) begin : g_bad_channel_w
    $error("st_packet_channel_arbiter: CHANNEL_W too narrow for NUM_IN");
  end

  logic [MAX_IN-1:0]        valid_ext;
  logic [MAX_IN-1:0]        sop_ext;
  logic [MAX_IN-1:0]        eop_ext;
  logic [MAX_IN-1:0]        ready_ext;
  logic [MAX_IN*DATA_W-1:0] data_ext;

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] sel;
  logic             xfer;
  logic             err;
  logic             accept;
  rr_t              rr;

  assign valid_ext = MAX_IN'(in_valid);
  assign sop_ext   = MAX_IN'(in_startofpacket);
  assign eop_ext   = MAX_IN'(in_endofpacket);
  assign data_ext  = (MAX_IN*DATA_W)'(in_data);
  assign in_ready  = ready_ext[NUM_IN-1:0];

  always_comb begin
    next_state = state;
    ready_ext  = '0;
    sel        = grant_idx;
    xfer       = 1'b0;
    err        = 1'b0;
    rr         = rr_next(valid_ext, last_grant, NUM_IN);
    case (state)
      IDLE: begin
        if (rr.found && accept) begin
          sel            = rr.idx;
          ready_ext[sel] = 1'b1;
          xfer           = 1'b1;
          err            = !sop_ext[sel];
          if (!eop_ext[sel]) next_state = BUSY;
        end
      end
      BUSY: begin
        ready_ext[grant_idx] = accept;
        xfer = accept && valid_ext[grant_idx];
        // A stray SOP is flagged but does not end the grant; only EOP does.
        err  = xfer && sop_ext[grant_idx];
        if (xfer && eop_ext[grant_idx]) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant_idx  <= '0;
      last_grant <= IDX_W'(NUM_IN - 1);
      proto_err  <= 1'b0;
    end else begin
      state     <= next_state;
      proto_err <= err;
      if (state == IDLE && xfer) grant_idx <= sel;
      if (xfer && eop_ext[sel]) last_grant <= sel;
    end
  end

  st_out_reg #(
    .DATA_W   (DATA_W),
    .CHANNEL_W(CHANNEL_W)
  ) u_out_reg (
    .clk              (clk),
    .reset            (reset),
    .load             (xfer),
    .data             (data_ext[sel*DATA_W +: DATA_W]),
    .channel          (CHANNEL_W'(sel)),
    .sop              (sop_ext[sel]),
    .eop              (eop_ext[sel]),
    .out_ready        (out_ready),
    .accept           (accept),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_channel      (out_channel),
    .out_startofpacket(out_startofpacket),
    .out_endofpacket  (out_endofpacket)
  );

endmodule
